// File: rtl/ydata_receiver_if.sv
// rtl/ydata_receiver_if.sv - Y-link receive side and local pop port bundled as one interface
interface ydata_receiver_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              YREQ;
  logic [DATA_W-1:0] YDATA;
  logic              YPARITY;
  logic              PARITYSEL;
  logic              YACK;
  logic [DATA_W-1:0] RDATA;
  logic              RPERR;
  logic              RVALID;
  logic              RREADY;
  logic [CNT_W-1:0]  COUNT;
  logic              FULL;
  logic              PERR;
  logic              PERR_CLR;

  // master: write-buffer sender plus local consumer; slave: the receiver
  modport master (
    output YREQ, YDATA, YPARITY, PARITYSEL, RREADY, PERR_CLR,
    input  YACK, RDATA, RPERR, RVALID, COUNT, FULL, PERR
  );

  modport slave (
    input  YREQ, YDATA, YPARITY, PARITYSEL, RREADY, PERR_CLR,
    output YACK, RDATA, RPERR, RVALID, COUNT, FULL, PERR
  );
endinterface

// File: rtl/ydata_receiver.sv
// rtl/ydata_receiver.sv - Y-link four-phase receiver with parity check and tagged FIFO
// Optional: YRX_PARITY_DROP_EN discards words that fail parity instead of queueing them.
module ydata_receiver #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  ydata_receiver_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t state, state_nxt;

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             perr_flag;

  logic full, capture, perr, push, pop;

  assign full = (count == CNT_W'(DEPTH));
  assign perr = ((^bus.YDATA) ^ bus.YPARITY) != bus.PARITYSEL;
  assign pop  = (count != '0) && bus.RREADY;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // a full FIFO stalls the handshake, even if a pop happens this cycle
        if (bus.YREQ && !full) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!bus.YREQ) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef YRX_PARITY_DROP_EN
  assign push = capture && !perr;
`else
  assign push = capture;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      perr_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      // a same-cycle error beats the clear
      if (capture && perr)   perr_flag <= 1'b1;
      else if (bus.PERR_CLR) perr_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {perr, bus.YDATA};
  end

  assign bus.YACK   = (state == ACK);
  assign bus.RDATA  = mem[rd_ptr][DATA_W-1:0];
`ifdef YRX_PARITY_DROP_EN
  assign bus.RPERR  = 1'b0;
`else
  assign bus.RPERR  = mem[rd_ptr][DATA_W];
`endif
  assign bus.RVALID = (count != '0);
  assign bus.COUNT  = count;
  assign bus.FULL   = full;
  assign bus.PERR   = perr_flag;
endmodule

// File: tb/tb_ydata_receiver.sv
// tb/tb_ydata_receiver.sv - directed, table-driven checks of ydata_receiver
module tb_ydata_receiver;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ydata_receiver_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  ydata_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic        bad;
    logic        exp_tag;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic par_for(input logic [31:0] d, input logic sel, input logic bad);
    return (^d) ^ sel ^ bad;
  endfunction

  // raise YREQ with a word and wait (bounded) for YACK; lat = negedges waited
  task automatic raise_req(input logic [31:0] d, input logic sel, input logic bad, output int lat);
    bus.YDATA     = d;
    bus.PARITYSEL = sel;
    bus.YPARITY   = par_for(d, sel, bad);
    bus.YREQ      = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.YACK) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("yack_rise_timeout", 64'(bus.YACK), 64'd1);
  endtask

  task automatic drop_req(output int lat);
    bus.YREQ = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!bus.YACK) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("yack_fall_timeout", 64'(bus.YACK), 64'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic sel, input logic bad);
    int l1, l2;
    raise_req(d, sel, bad, l1);
    drop_req(l2);
  endtask

  task automatic pop_check(input string name, input logic [31:0] d, input logic tag);
    check({name, "_rvalid"}, 64'(bus.RVALID), 64'd1);
    check({name, "_rdata"}, 64'(bus.RDATA), 64'(d));
    check({name, "_rperr"}, 64'(bus.RPERR), 64'(tag));
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  initial begin
    int l1, l2;
    bus.YREQ = 1'b0; bus.YDATA = '0; bus.YPARITY = 1'b0; bus.PARITYSEL = 1'b0;
    bus.RREADY = 1'b0; bus.PERR_CLR = 1'b0;

    // 1: reset with YREQ held high
    rst = 1'b1; bus.YREQ = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_yack", 64'(bus.YACK), 64'd0);
      check("rst_count", 64'(bus.COUNT), 64'd0);
      check("rst_rvalid", 64'(bus.RVALID), 64'd0);
      check("rst_perr", 64'(bus.PERR), 64'd0);
      check("rst_full", 64'(bus.FULL), 64'd0);
    end
    rst = 1'b0; bus.YREQ = 1'b0;
    @(negedge clk);

    // 2: single word, latency both edges
    bus.YDATA = 32'hA5A5_0001; bus.YPARITY = 1'b1; bus.PARITYSEL = 1'b0;
    raise_req(32'hA5A5_0001, 1'b0, 1'b0, l1);
    check("single_ack_lat", 64'(l1), 64'd1);
    drop_req(l2);
    check("single_release_lat", 64'(l2), 64'd1);
    check("single_count", 64'(bus.COUNT), 64'd1);
    check("single_perr", 64'(bus.PERR), 64'd0);
    pop_check("single", 32'hA5A5_0001, 1'b0);
    check("single_empty", 64'(bus.RVALID), 64'd0);

    // 3: fill to DEPTH, fifth request stalls until a pop
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0, 1'b0);
    check("fill_count", 64'(bus.COUNT), 64'd4);
    check("fill_full", 64'(bus.FULL), 64'd1);
    bus.YDATA = 32'd5; bus.PARITYSEL = 1'b0; bus.YPARITY = par_for(32'd5, 1'b0, 1'b0);
    bus.YREQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_stall_yack", 64'(bus.YACK), 64'd0);
    end
    check("full_hold_count", 64'(bus.COUNT), 64'd4);
    check("full_pop_rdata", 64'(bus.RDATA), 64'd1);
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    check("full_pop_same_cycle_yack", 64'(bus.YACK), 64'd0);
    check("full_pop_count", 64'(bus.COUNT), 64'd3);
    @(negedge clk);
    check("fifth_acked", 64'(bus.YACK), 64'd1);
    check("fifth_count", 64'(bus.COUNT), 64'd4);
    drop_req(l2);
    for (int i = 2; i <= 5; i++) pop_check("wrap_pop", 32'(i), 1'b0);
    check("wrap_empty", 64'(bus.COUNT), 64'd0);

    // 4: table of parity cases; the last is the spec's odd-parity zero word
    vecs[0] = '{32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h1234_5678, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0001, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      raise_req(vecs[i].data, vecs[i].sel, vecs[i].bad, l1);
      check("vec_acked", 64'(l1 != 0), 64'd1);
      drop_req(l2);
`ifdef YRX_PARITY_DROP_EN
      if (vecs[i].exp_tag) begin
        check("vec_dropped_count", 64'(bus.COUNT), 64'd0);
      end else begin
        pop_check("vec", vecs[i].data, 1'b0);
      end
`else
      pop_check("vec", vecs[i].data, vecs[i].exp_tag);
`endif
      if (i == 0) check("perr_still_clear", 64'(bus.PERR), 64'd0);
    end
    check("perr_sticky", 64'(bus.PERR), 64'd1);
    bus.PERR_CLR = 1'b1;
    @(negedge clk);
    bus.PERR_CLR = 1'b0;
    check("perr_cleared", 64'(bus.PERR), 64'd0);

    // 5: simultaneous push and pop at COUNT=2
    send(32'hA, 1'b0, 1'b0);
    send(32'hB, 1'b0, 1'b0);
    check("pp_pre_count", 64'(bus.COUNT), 64'd2);
    check("pp_head", 64'(bus.RDATA), 64'hA);
    bus.YDATA = 32'hC; bus.PARITYSEL = 1'b0; bus.YPARITY = par_for(32'hC, 1'b0, 1'b0);
    bus.YREQ = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    check("pp_yack", 64'(bus.YACK), 64'd1);
    check("pp_count", 64'(bus.COUNT), 64'd2);
    drop_req(l2);
    pop_check("pp_pop", 32'hB, 1'b0);
    pop_check("pp_pop", 32'hC, 1'b0);

    // 6: reset while YACK=1 and COUNT=3
    send(32'h11, 1'b0, 1'b0);
    send(32'h22, 1'b0, 1'b0);
    raise_req(32'h33, 1'b0, 1'b0, l1);
    check("mid_yack", 64'(bus.YACK), 64'd1);
    check("mid_count", 64'(bus.COUNT), 64'd3);
    rst = 1'b1; bus.YREQ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_yack", 64'(bus.YACK), 64'd0);
    check("mid_rst_count", 64'(bus.COUNT), 64'd0);
    check("mid_rst_rvalid", 64'(bus.RVALID), 64'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
